i2c_byte_sequencer: RTL and testbench

//  Single-byte I2C master controller: accepts one command (7-bit addr, R/W, write byte), sequences

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_phase_gen.sv | 62 ++++++
 rtl/i2c_byte_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_i2c_byte_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the single-byte I2C master: FSM states, SCL quarter phases
// and a small state classification helper.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_AACK  = 4'd3,
        ST_WRITE = 4'd4,
        ST_DACK  = 4'd5,
        ST_READ  = 4'd6,
        ST_MNACK = 4'd7,
        ST_STOP  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

    // States that move one bit per SCL period and use the bit counter.
    function automatic logic is_shift_state(input state_t s);
        return (s == ST_ADDR) || (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase timebase for one SCL period, with slave clock-stretch hold
// while the master has released SCL in Q2 but the line is still low.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int DIVIDER = 250,
    parameter int CBITS   = 10
)(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     run,
    input  logic     scl_oe,
    input  logic     scl_in,
    output quarter_t quarter,
    output logic     q1_first,
    output logic     q3_first,
    output logic     wrap
);

    localparam logic [CBITS-1:0] CNT_ZERO = {CBITS{1'b0}};
    localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
    localparam logic [CBITS-1:0] Q1_START = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] Q2_START = CBITS'(2 * DIVIDER);
    localparam logic [CBITS-1:0] Q3_START = CBITS'(3 * DIVIDER);
    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(4 * DIVIDER - 1);

    logic [CBITS-1:0] cnt_r;
    logic             hold_s;

    // Quarter decode from the phase count.
    always_comb begin
        if (cnt_r < Q1_START) begin
            quarter = Q0;
        end else if (cnt_r < Q2_START) begin
            quarter = Q1;
        end else if (cnt_r < Q3_START) begin
            quarter = Q2;
        end else begin
            quarter = Q3;
        end
    end

    assign hold_s   = run && (quarter == Q2) && !scl_oe && !scl_in;
    assign q1_first = run && (cnt_r == Q1_START);
    assign q3_first = run && (cnt_r == Q3_START);
    assign wrap     = run && !hold_s && (cnt_r == CNT_LAST);

    // Phase counter: cleared on accept, frozen while idle or stretched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (run && !hold_s) begin
            cnt_r <= (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Single-byte I2C master: START, address, ACK, one data byte, ACK/NACK, STOP,
// on open-drain pads with registered output enables.
module i2c_byte_sequencer
    import i2c_pkg::*;
#(
    parameter int DIVIDER = 250,
    parameter int CBITS   = 10
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       ack_err,
    output logic       done,
    output logic       busy,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    state_t     state_r;
    state_t     state_s;
    quarter_t   quarter_s;
    logic       q1_first_s;
    logic       q3_first_s;
    logic       wrap_s;
    logic       accept_s;
    logic       run_s;
    logic       low_phase_s;
    logic       high_phase_s;
    logic       last_bit_s;
    logic       done_s;
    logic       scl_oe_s;
    logic       sda_oe_s;
    logic       scl_oe_r;
    logic       sda_oe_r;
    logic       done_r;
    logic       ack_err_r;
    logic [7:0] rdata_r;
    logic [7:0] addr_byte_r;
    logic [7:0] wdata_r;
    logic [2:0] bit_cnt_r;

    assign cmd_ready    = (state_r == ST_IDLE);
    assign busy         = ~cmd_ready;
    assign accept_s     = cmd_valid && cmd_ready;
    assign run_s        = (state_r != ST_IDLE);
    assign low_phase_s  = (quarter_s == Q0) || (quarter_s == Q1);
    assign high_phase_s = ~low_phase_s;
    assign last_bit_s   = (bit_cnt_r == 3'd0);
    assign done_s       = (state_r == ST_STOP) && wrap_s;

    assign scl_oe  = scl_oe_r;
    assign sda_oe  = sda_oe_r;
    assign done    = done_r;
    assign ack_err = ack_err_r;
    assign rdata   = rdata_r;

    i2c_phase_gen #(
        .DIVIDER (DIVIDER),
        .CBITS   (CBITS)
    ) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept_s),
        .run      (run_s),
        .scl_oe   (scl_oe_r),
        .scl_in   (scl_in),
        .quarter  (quarter_s),
        .q1_first (q1_first_s),
        .q3_first (q3_first_s),
        .wrap     (wrap_s)
    );

    // Next-state logic; every transition out of a busy state happens at a period wrap.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = accept_s ? ST_START : ST_IDLE;
            ST_START: state_s = wrap_s ? ST_ADDR : ST_START;
            ST_ADDR:  state_s = (wrap_s && last_bit_s) ? ST_AACK : ST_ADDR;
            ST_AACK: begin
                if (!wrap_s) begin
                    state_s = ST_AACK;
                end else if (ack_err_r) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = addr_byte_r[0] ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: state_s = (wrap_s && last_bit_s) ? ST_DACK : ST_WRITE;
            ST_DACK:  state_s = wrap_s ? ST_STOP : ST_DACK;
            ST_READ:  state_s = (wrap_s && last_bit_s) ? ST_MNACK : ST_READ;
            ST_MNACK: state_s = wrap_s ? ST_STOP : ST_MNACK;
            ST_STOP:  state_s = wrap_s ? ST_IDLE : ST_STOP;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Pad targets; data-carrying states only move SDA at the start of Q1 while SCL is low.
    always_comb begin
        scl_oe_s = 1'b0;
        sda_oe_s = sda_oe_r;
        case (state_r)
            ST_IDLE: begin
                sda_oe_s = 1'b0;
            end
            ST_START: begin
                sda_oe_s = high_phase_s;
            end
            ST_ADDR: begin
                scl_oe_s = low_phase_s;
                if (q1_first_s) begin
                    sda_oe_s = ~addr_byte_r[bit_cnt_r];
                end else begin
                    sda_oe_s = sda_oe_r;
                end
            end
            ST_WRITE: begin
                scl_oe_s = low_phase_s;
                if (q1_first_s) begin
                    sda_oe_s = ~wdata_r[bit_cnt_r];
                end else begin
                    sda_oe_s = sda_oe_r;
                end
            end
            ST_AACK, ST_DACK, ST_READ, ST_MNACK: begin
                scl_oe_s = low_phase_s;
                if (q1_first_s) begin
                    sda_oe_s = 1'b0;
                end else begin
                    sda_oe_s = sda_oe_r;
                end
            end
            ST_STOP: begin
                scl_oe_s = low_phase_s;
                sda_oe_s = (quarter_s != Q3);
            end
            default: begin
                scl_oe_s = 1'b0;
                sda_oe_s = 1'b0;
            end
        endcase
    end

    // State and pad-enable registers; reset releases the bus on the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            scl_oe_r <= 1'b0;
            sda_oe_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            scl_oe_r <= scl_oe_s;
            sda_oe_r <= sda_oe_s;
            done_r   <= done_s;
        end
    end

    // Command latch, bit counter and sampled results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_byte_r <= 8'h00;
            wdata_r     <= 8'h00;
            bit_cnt_r   <= 3'd7;
            ack_err_r   <= 1'b0;
            rdata_r     <= 8'h00;
        end else if (accept_s) begin
            addr_byte_r <= {cmd_addr, cmd_rw};
            wdata_r     <= cmd_wdata;
            bit_cnt_r   <= 3'd7;
            ack_err_r   <= 1'b0;
        end else begin
            // Decrementing past 0 lands on 7, which is the reload for the next byte.
            if (wrap_s && is_shift_state(state_r)) begin
                bit_cnt_r <= bit_cnt_r - 3'd1;
            end
            if (q3_first_s && ((state_r == ST_AACK) || (state_r == ST_DACK)) && sda_in) begin
                ack_err_r <= 1'b1;
            end
            if (q3_first_s && (state_r == ST_READ)) begin
                rdata_r <= {rdata_r[6:0], sda_in};
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Randomised bench for i2c_byte_sequencer: an SCL-edge-driven open-drain slave
// model plus a transaction-level reference for latency, ack_err and data.
module tb_i2c_byte_sequencer;

    localparam int DIVIDER = 4;
    localparam int CBITS   = 4;
    localparam int PERIOD  = 4 * DIVIDER;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr  = 7'h00;
    logic       cmd_rw    = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic [7:0] rdata;
    logic       ack_err;
    logic       done;
    logic       busy;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;

    logic       slave_sda = 1'b0;
    logic       hold      = 1'b0;

    assign scl_in = ~(scl_oe | hold);
    assign sda_in = ~(sda_oe | slave_sda);

    i2c_byte_sequencer #(.DIVIDER(DIVIDER), .CBITS(CBITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rdata     (rdata),
        .ack_err   (ack_err),
        .done      (done),
        .busy      (busy),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave configuration for the current transaction.
    logic       s_aack    = 1'b1;
    logic       s_dack    = 1'b1;
    logic       s_stretch = 1'b0;
    logic [7:0] s_rdata   = 8'h00;

    // Slave observation state.
    int         fe         = 0;
    logic       active     = 1'b0;
    logic [7:0] rx_addr    = 8'h00;
    logic [7:0] rx_data    = 8'h00;
    logic       rx_mack    = 1'b0;
    logic       stop_seen  = 1'b0;
    int         hcount     = 0;
    logic       prev_scl   = 1'b1;
    logic       prev_sda   = 1'b1;
    int         accepts    = 0;
    int         dones      = 0;
    int         accept_cyc = 0;
    int         done_cyc   = 0;

    // What the slave pulls SDA to after SCL falling edge number n of the frame.
    function automatic logic slave_drive(input int n, input logic [7:0] ra);
        logic [2:0] idx;
        idx = 3'(17 - n);
        if (n == 9)              return s_aack;
        if (n >= 10 && n <= 17)  return s_aack && ra[0] && !s_rdata[idx];
        if (n == 18)             return s_aack && !ra[0] && s_dack;
        return 1'b0;
    endfunction

    // Bus monitor and slave: reacts to SCL/SDA line events, never to DUT internals.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            accepts    <= accepts + 1;
            accept_cyc <= cyc + 1;
        end
        if (done) begin
            dones    <= dones + 1;
            done_cyc <= cyc;
        end
        if (!rst_n) begin
            slave_sda <= 1'b0;
            hold      <= 1'b0;
            active    <= 1'b0;
            fe        <= 0;
        end else begin
            if (scl_in && prev_scl && prev_sda && !sda_in) begin
                active    <= 1'b1;
                fe        <= 0;
                rx_addr   <= 8'h00;
                rx_data   <= 8'h00;
                rx_mack   <= 1'b0;
                stop_seen <= 1'b0;
                hcount    <= 0;
            end else if (scl_in && prev_scl && !prev_sda && sda_in) begin
                stop_seen <= 1'b1;
                active    <= 1'b0;
                slave_sda <= 1'b0;
            end else if (active && prev_scl && !scl_in) begin
                fe        <= fe + 1;
                slave_sda <= slave_drive(fe + 1, rx_addr);
                if (fe + 1 == 18 && s_stretch) hold <= 1'b1;
            end else if (active && !prev_scl && scl_in) begin
                if (fe >= 1 && fe <= 8)        rx_addr <= {rx_addr[6:0], sda_in};
                else if (fe >= 10 && fe <= 17) rx_data <= {rx_data[6:0], sda_in};
                else if (fe == 18)             rx_mack <= sda_in;
            end
            if (hold && !scl_oe) begin
                if (hcount == 10) hold <= 1'b0;
                else              hcount <= hcount + 1;
            end
        end
        prev_scl <= scl_in;
        prev_sda <= sda_in;
    end

    task automatic set_slave(input logic aack, input logic dack, input logic stretch, input logic [7:0] rd);
        s_aack    = aack;
        s_dack    = dack;
        s_stretch = stretch;
        s_rdata   = rd;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input logic aack, input logic dack, input logic stretch,
                           input logic [7:0] rd);
        int   a0;
        int   d0;
        int   n;
        int   exp_lat;
        logic exp_err;
        set_slave(aack, dack, stretch, rd);
        @(posedge clk); #1;
        a0        = accepts;
        d0        = dones;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        n = 0;
        while (accepts == a0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        check_val("accept", 32'(accepts - a0), 32'd1);
        n = 0;
        while (dones == d0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        exp_lat = (aack ? 20 : 11) * PERIOD + ((aack && stretch) ? 10 : 0);
        exp_err = !aack || (!rw && !dack);
        check_val("latency", 32'(done_cyc - accept_cyc), 32'(exp_lat));
        check_val("ack_err", 32'(ack_err), 32'(exp_err));
        check_val("rx_addr", 32'(rx_addr), 32'({a, rw}));
        if (aack && !rw) check_val("rx_wdata", 32'(rx_data), 32'(wd));
        if (aack && rw) begin
            check_val("rdata", 32'(rdata), 32'(rd));
            check_val("master_nack", 32'(rx_mack), 32'd1);
        end
        check_val("stop_seen", 32'(stop_seen), 32'd1);
        @(posedge clk); #1;
        check_val("done_pulse", 32'(dones - d0), 32'd1);
        check_val("ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int a0;
        int d0;
        int n;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_scl_oe", 32'(scl_oe), 32'd0);
        check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_val("rst_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_ack_err", 32'(ack_err), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
        run_txn(7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3);
        repeat (5) @(posedge clk);
        #1;
        check_val("rdata_held", 32'(rdata), 32'h0000_00C3);
        run_txn(7'h2A, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00);
        run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h00);
        run_txn(7'h11, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00);
        run_txn(7'h7F, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h81);

        // Reset during WRITE bit 3 (period 14 after accept).
        set_slave(1'b1, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        a0        = accepts;
        cmd_addr  = 7'h22;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'hF0;
        cmd_valid = 1'b1;
        n = 0;
        while (accepts == a0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        repeat (14 * PERIOD + 5) @(posedge clk);
        #1;
        check_val("busy_before_rst", 32'(busy), 32'd1);
        d0    = dones;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_scl_oe", 32'(scl_oe), 32'd0);
        check_val("abort_sda_oe", 32'(sda_oe), 32'd0);
        check_val("abort_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_no_done", 32'(dones - d0), 32'd0);

        // cmd_valid held through a transfer: one accept, then a second in the done cycle.
        set_slave(1'b1, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        a0        = accepts;
        d0        = dones;
        cmd_addr  = 7'h33;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h3C;
        cmd_valid = 1'b1;
        n = 0;
        while (dones == d0 && n < 2000) begin
            @(posedge clk); #1;
            if (n == 100) check_val("hold_single_accept", 32'(accepts - a0), 32'd1);
            n++;
        end
        check_val("hold_reaccept", 32'(accepts - a0), 32'd2);
        check_val("hold_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        n = 0;
        while (dones == d0 + 1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("hold_second_done", 32'(dones - d0), 32'd2);
        check_val("hold_rx_wdata", 32'(rx_data), 32'h0000_003C);

        for (int i = 0; i < 12; i++) begin
            run_txn(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
